// File: rtl/ha_serial_add_seq.sv
// ha_serial_add_seq
// Bit-serial add sequencer built from two half-adder cells plus an OR, with the
// carry held in a flop between cycles. Operands are consumed LSB first, one bit
// per enabled cycle, and the result is shifted into the sum register from the MSB.
// Optional feature macro: HA_SERIAL_SUB_EN adds a 'sub' input that turns the
// operation into op_a - op_b (op_b inverted on capture, carry seeded with 1).

// Basic half-adder cell shared by both stages of the serial full adder
module HalfAdder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module ha_serial_add_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
`ifdef HA_SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_bitCnt;
  logic             r_carry;
  logic             r_cout;

  logic w_s1;
  logic w_c1;
  logic w_s;
  logic w_c2;
  logic w_carryNext;
  logic w_accept;
  logic w_lastBit;
  logic [WIDTH-1:0] w_loadB;
  logic             w_loadCarry;

  // First stage adds the two operand bits, second stage folds in the held carry
  HalfAdder u_haStage1 (
    .a (r_opA[0]),
    .b (r_opB[0]),
    .s (w_s1),
    .c (w_c1)
  );

  HalfAdder u_haStage2 (
    .a (w_s1),
    .b (r_carry),
    .s (w_s),
    .c (w_c2)
  );

  assign w_carryNext = w_c1 | w_c2;
  assign w_lastBit   = (r_bitCnt == LAST_BIT);

  // A start is only honoured when not already running; DONE counts as idle
  assign w_accept = ena && start && ((r_state == IDLE) || (r_state == DONE));

`ifdef HA_SERIAL_SUB_EN
  assign w_loadB     = sub ? ~op_b : op_b;
  assign w_loadCarry = sub;
`else
  assign w_loadB     = op_b;
  assign w_loadCarry = 1'b0;
`endif

  // State register; ena low freezes the FSM in place
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic for the IDLE/RUN/DONE sequence
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Datapath: capture operands on start, then shift one bit per enabled RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA    <= '0;
      r_opB    <= '0;
      r_sum    <= '0;
      r_bitCnt <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
    end else if (ena) begin
      if (w_accept) begin
        r_opA    <= op_a;
        r_opB    <= w_loadB;
        r_bitCnt <= '0;
        r_carry  <= w_loadCarry;
      end else if (r_state == RUN) begin
        r_opA    <= r_opA >> 1;
        r_opB    <= r_opB >> 1;
        r_sum    <= {w_s, r_sum[WIDTH-1:1]};
        r_carry  <= w_carryNext;
        r_bitCnt <= r_bitCnt + CW'(1);
        if (w_lastBit) begin
          r_cout <= w_carryNext;
        end
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_ha_serial_add_seq.sv
// tb_ha_serial_add_seq
// Directed checks of the serial add sequencer with WIDTH=4: reset state,
// handshake timing, wrap/overflow, start-while-busy, reset abort, ena stalls
// and back-to-back starts. Subtract vectors build only with HA_SERIAL_SUB_EN.

module tb_ha_serial_add_seq;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             ena;
  logic             start;
`ifdef HA_SERIAL_SUB_EN
  logic             sub;
`endif
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checkCount = 0;
  int passCount  = 0;

  ha_serial_add_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (start),
`ifdef HA_SERIAL_SUB_EN
    .sub   (sub),
`endif
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pulse start with the given operands; returns in the first RUN cycle (T+1)
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full operation with busy/done timing and result checks
  task automatic runOp(input string tag, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] expSum,
                       input logic expCout);
    applyStimulus(a, b);
    for (int i = 0; i < WIDTH; i++) begin
      checkOutput({tag, "_busy"}, busy, 1);
      checkOutput({tag, "_noDone"}, done, 0);
      tick();
    end
    checkOutput({tag, "_done"}, done, 1);
    checkOutput({tag, "_busyLow"}, busy, 0);
    checkOutput({tag, "_sum"}, sum, expSum);
    checkOutput({tag, "_cout"}, cout, expCout);
    tick();
    checkOutput({tag, "_donePulse"}, done, 0);
    checkOutput({tag, "_sumHeld"}, sum, expSum);
  endtask

  initial begin
    rst   = 1'b1;
    ena   = 1'b1;
    start = 1'b0;
`ifdef HA_SERIAL_SUB_EN
    sub   = 1'b0;
`endif
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_sum", sum, 0);
    checkOutput("rst_cout", cout, 0);

    // Basic add and wrap-around
    runOp("add3p5", 4'd3, 4'd5, 4'd8, 1'b0);
    runOp("wrap15p1", 4'd15, 4'd1, 4'd0, 1'b1);
    runOp("zero", 4'd0, 4'd0, 4'd0, 1'b0);

    // Start while busy with changed operands is ignored
    applyStimulus(4'd6, 4'd7);
    tick();
    op_a  = 4'd1;
    op_b  = 4'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busyStart_busy", busy, 1);
    tick();
    tick();
    checkOutput("busyStart_done", done, 1);
    checkOutput("busyStart_sum", sum, 13);
    checkOutput("busyStart_cout", cout, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("busyStart_singleDone", done, 0);
      checkOutput("busyStart_idle", busy, 0);
    end

    // Reset in the middle of a run aborts without a done pulse
    applyStimulus(4'd5, 4'd6);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRst_busy", busy, 0);
    checkOutput("midRst_sum", sum, 0);
    checkOutput("midRst_cout", cout, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("midRst_noDone", done, 0);
      tick();
    end
    runOp("afterRst2p2", 4'd2, 4'd2, 4'd4, 1'b0);

    // ena held low for three cycles mid-run delays done to T+8
    applyStimulus(4'd9, 4'd4);
    tick();
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("stall_busyHeld", busy, 1);
      checkOutput("stall_noDone", done, 0);
    end
    ena = 1'b1;
    tick();
    tick();
    checkOutput("stall_T7_busy", busy, 1);
    checkOutput("stall_T7_noDone", done, 0);
    tick();
    checkOutput("stall_done", done, 1);
    checkOutput("stall_sum", sum, 13);
    checkOutput("stall_cout", cout, 0);
    tick();

    // ena dropping during DONE holds the done pulse
    applyStimulus(4'd1, 4'd2);
    for (int i = 0; i < WIDTH; i++) tick();
    checkOutput("doneHold_done", done, 1);
    ena = 1'b0;
    tick();
    checkOutput("doneHold_frozen1", done, 1);
    tick();
    checkOutput("doneHold_frozen2", done, 1);
    checkOutput("doneHold_sum", sum, 3);
    ena = 1'b1;
    tick();
    checkOutput("doneHold_release", done, 0);

    // Start seen in DONE goes straight back to RUN
    applyStimulus(4'd4, 4'd4);
    for (int i = 0; i < WIDTH; i++) tick();
    checkOutput("b2b_firstDone", done, 1);
    checkOutput("b2b_firstSum", sum, 8);
    applyStimulus(4'd7, 4'd8);
    checkOutput("b2b_busy", busy, 1);
    checkOutput("b2b_noDone", done, 0);
    for (int i = 0; i < WIDTH - 1; i++) tick();
    checkOutput("b2b_lastBusy", busy, 1);
    tick();
    checkOutput("b2b_secondDone", done, 1);
    checkOutput("b2b_secondSum", sum, 15);
    checkOutput("b2b_secondCout", cout, 0);
    tick();

`ifdef HA_SERIAL_SUB_EN
    // Subtraction: cout=1 means no borrow
    sub = 1'b1;
    runOp("sub5m3", 4'd5, 4'd3, 4'd2, 1'b1);
    runOp("sub3m5", 4'd3, 4'd5, 4'd14, 1'b0);
    sub = 1'b0;
    runOp("subOffAdd", 4'd3, 4'd5, 4'd8, 1'b0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
